// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the CPU memory bus responder.
//   state_t          : responder FSM states (IDLE, WAIT, DONE)
//   RW_READ/RW_WRITE : encoding of the CPU Rw line
//   BUS_ADDR_W/BUS_DATA_W : default bus widths
package bus_pkg;
  localparam int BUS_ADDR_W = 8;
  localparam int BUS_DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/bus_memory_responder_mem.sv
// mem_array: 2^ADDR_W x DATA_W storage, one write port, one registered read
// port, no reset (contents are undefined after power-up).
//   i_clk            : clock, rising edge
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : read request; o_rdata updates on the edge i_re is high
//   o_rdata          : registered read data (holds between reads)
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    // A read on the same edge as a write to the same word sees the new data.
    if (i_re) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: memory-side responder for the CPU Address_Bus /
// Data_Bus / Rw / En interface, with programmable wait states and a side-band
// loader port.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   Address_Bus, Rw, En : CPU request (En sampled only in IDLE)
//   Data_Bus        : shared bus; driven by this block only in a read's Ready cycle
//   Ready           : one-cycle completion strobe
//   Load_En/Load_Addr/Load_Data, Load_Ack : loader write port (IDLE only)
//   Fault           : sticky write-protect violation flag
// Optional feature macro BUS_ROM_PROTECT_EN: CPU writes to addresses
// <= ROM_TOP are dropped and set Fault. Undefined: all writes commit, Fault = 0.
module bus_memory_responder
  import bus_pkg::*;
#(
  parameter int          ADDR_W      = BUS_ADDR_W,
  parameter int          DATA_W      = BUS_DATA_W,
  parameter int          WAIT_STATES = 1,
  parameter int unsigned ROM_TOP     = 'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Address_Bus,
  inout  wire  [DATA_W-1:0] Data_Bus,
  input  logic              Rw,
  input  logic              En,
  output logic              Ready,
  input  logic              Load_En,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [DATA_W-1:0] Load_Data,
  output logic              Load_Ack,
  output logic              Fault
);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

`ifdef BUS_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ready;
  logic              r_ack;
  logic              r_drive;

  logic              w_commit;
  logic              w_in_rom;
  logic              w_protect;
  logic              w_ld_we;
  logic              w_cpu_we;
  logic [DATA_W-1:0] w_rdata;

  // The access resolves on the edge that leaves WAIT.
  assign w_commit  = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_in_rom  = 32'(r_addr) <= ROM_TOP;
  assign w_protect = ROM_PROTECT && w_in_rom;
  // Loader owns the write port in IDLE; the FSM is pinned to IDLE during rst,
  // so gate with rst to keep a held Load_En from writing while in reset.
  assign w_ld_we   = (r_state == IDLE) && Load_En && !rst;
  assign w_cpu_we  = w_commit && (r_rw == RW_WRITE) && !w_protect;

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .i_clk   (clk),
    .i_we    (w_ld_we | w_cpu_we),
    .i_waddr (w_ld_we ? Load_Addr : r_addr),
    .i_wdata (w_ld_we ? Load_Data : r_wdata),
    .i_re    (w_commit && (r_rw == RW_READ)),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rw    <= RW_WRITE;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
      r_drive <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Load_En) begin
            r_ack <= 1'b1;
          end else if (En) begin
            r_addr  <= Address_Bus;
            r_rw    <= Rw;
            r_wdata <= Data_Bus;
            r_cnt   <= WAIT_CNT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_ready <= 1'b1;
            r_drive <= (r_rw == RW_READ);
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BUS_ROM_PROTECT_EN
  logic r_fault;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_fault <= 1'b0;
    else if (w_commit && (r_rw == RW_WRITE) && w_in_rom) r_fault <= 1'b1;
  end
  assign Fault = r_fault;
`else
  assign Fault = 1'b0;
`endif

  assign Ready    = r_ready;
  assign Load_Ack = r_ack;
  // r_drive is cleared by rst, so the bus is released asynchronously.
  assign Data_Bus = r_drive ? w_rdata : {DATA_W{1'bz}};
endmodule
